// File: rtl/loop_seq_ctrl_mux3_pkg.sv
// Shared constants for the loop sequencer / 3:1 operand selector slice.
package loop_seq_ctrl_mux3_pkg;

  localparam int         DEF_DIN_WIDTH = 32;
  localparam int         DEF_SEL_WIDTH = 2;
  // Highest meaningful select index; anything at or above it picks din2.
  localparam logic [1:0] SEL_LAST      = 2'd2;

endpackage

// File: rtl/loop_seq_ctrl_mux3_if.sv
// Parent/loop-body handshake plus mux operand bus for loop_seq_ctrl_mux3.
interface loop_seq_ctrl_mux3_if
  import loop_seq_ctrl_mux3_pkg::*;
#(
  parameter int DIN_WIDTH = DEF_DIN_WIDTH,
  parameter int SEL_WIDTH = DEF_SEL_WIDTH
);

  logic                 ap_start;
  logic                 ap_ready;
  logic                 ap_done;
  logic                 ap_start_int;
  logic                 ap_loop_init;
  logic                 ap_ready_int;
  logic                 ap_loop_exit_ready;
  logic                 ap_loop_exit_done;
  logic                 ap_continue_int;
  logic [DIN_WIDTH-1:0] din0;
  logic [DIN_WIDTH-1:0] din1;
  logic [DIN_WIDTH-1:0] din2;
  logic [SEL_WIDTH-1:0] sel;
  logic [DIN_WIDTH-1:0] dout;

  modport master (
    output ap_start, ap_ready_int, ap_loop_exit_ready, ap_loop_exit_done,
    output din0, din1, din2, sel,
    input  ap_ready, ap_done, ap_start_int, ap_loop_init, ap_continue_int,
    input  dout
  );

  modport slave (
    input  ap_start, ap_ready_int, ap_loop_exit_ready, ap_loop_exit_done,
    input  din0, din1, din2, sel,
    output ap_ready, ap_done, ap_start_int, ap_loop_init, ap_continue_int,
    output dout
  );

endinterface

// File: rtl/loop_seq_ctrl_mux3_sel.sv
// Combinational 3:1 operand selector; select values past the last input alias din2.
module loop_mux3_sel
  import loop_seq_ctrl_mux3_pkg::*;
#(
  parameter int DIN_WIDTH = DEF_DIN_WIDTH,
  parameter int SEL_WIDTH = DEF_SEL_WIDTH
) (
  input  logic [SEL_WIDTH-1:0] sel_i,
  input  logic [DIN_WIDTH-1:0] din0_i,
  input  logic [DIN_WIDTH-1:0] din1_i,
  input  logic [DIN_WIDTH-1:0] din2_i,
  output logic [DIN_WIDTH-1:0] dout_o
);

  always_comb begin
    dout_o = din2_i;
    if (sel_i == '0) begin
      dout_o = din0_i;
    end else if (sel_i < SEL_WIDTH'(SEL_LAST)) begin
      dout_o = din1_i;
    end
  end

endmodule

// File: rtl/loop_seq_ctrl_mux3.sv
// Loop flow-control sequencer bridging parent ap_* handshake to the loop body,
// bundled with the 3:1 operand selector used by the loop body.
module loop_seq_ctrl_mux3
  import loop_seq_ctrl_mux3_pkg::*;
#(
  parameter int ID        = 1,
  parameter int NUM_STAGE = 1,
  parameter int DIN_WIDTH = DEF_DIN_WIDTH,
  parameter int SEL_WIDTH = DEF_SEL_WIDTH
) (
  input logic                ap_clk,
  input logic                ap_rst,
  loop_seq_ctrl_mux3_if.slave bus
);

  if (NUM_STAGE != 1 || ID < 0) begin : g_cfg_err
    $error("loop_seq_ctrl_mux3: only a combinational selector (NUM_STAGE=1) exists");
  end

  logic init_q, init_d;
  logic done_q, done_d;

  // Exit re-arms the init flag even if the body also consumed an iteration.
  always_comb begin
    init_d = init_q;
    if (bus.ap_loop_exit_ready) begin
      init_d = 1'b1;
    end else if (bus.ap_ready_int) begin
      init_d = 1'b0;
    end
  end

  // Remember completion until the parent issues a new start.
  always_comb begin
    done_d = done_q;
    if (bus.ap_loop_exit_done) begin
      done_d = 1'b1;
    end else if (bus.ap_start) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      init_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      init_q <= init_d;
      done_q <= done_d;
    end
  end

  assign bus.ap_start_int    = bus.ap_start;
  assign bus.ap_continue_int = 1'b1;
  assign bus.ap_ready        = bus.ap_loop_exit_ready;
  assign bus.ap_loop_init    = init_q & bus.ap_start;
  assign bus.ap_done         = bus.ap_loop_exit_done | (done_q & ~bus.ap_start);

  loop_mux3_sel #(
    .DIN_WIDTH (DIN_WIDTH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_sel (
    .sel_i  (bus.sel),
    .din0_i (bus.din0),
    .din1_i (bus.din1),
    .din2_i (bus.din2),
    .dout_o (bus.dout)
  );

endmodule

// File: tb/tb_loop_seq_ctrl_mux3.sv
// Bench for loop_seq_ctrl_mux3: control sequence table, async reset and mux corners.
module tb_loop_seq_ctrl_mux3;

  typedef struct {
    logic        rst;
    logic        start;
    logic        rdy_int;
    logic        ex_rdy;
    logic        ex_done;
    logic [1:0]  sel;
    logic [4:0]  ctrl;   // {ap_ready, ap_done, ap_start_int, ap_loop_init, ap_continue_int}
    logic [31:0] dout;
  } vec_t;

  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] dout;
  } exp_t;

  localparam logic [31:0] D0 = 32'h0000_0005;
  localparam logic [31:0] D1 = 32'h7FFF_FFFF;
  localparam logic [31:0] D2 = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  loop_seq_ctrl_mux3_if #(.DIN_WIDTH(32), .SEL_WIDTH(2)) bus ();

  loop_seq_ctrl_mux3 #(
    .ID        (1),
    .NUM_STAGE (1),
    .DIN_WIDTH (32),
    .SEL_WIDTH (2)
  ) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus.slave)
  );

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t tbl[18];

  function automatic vec_t mk(input logic r, input logic st, input logic ri,
                              input logic er, input logic ed, input logic [1:0] s,
                              input logic [4:0] c, input logic [31:0] d);
    vec_t v;
    v.rst = r; v.start = st; v.rdy_int = ri; v.ex_rdy = er; v.ex_done = ed;
    v.sel = s; v.ctrl = c; v.dout = d;
    return v;
  endfunction

  task automatic push_exp(input logic [4:0] c, input logic [31:0] d);
    exp_t e;
    e.ctrl = c;
    e.dout = d;
    sb_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t       e;
    logic [4:0] act;
    act = {bus.ap_ready, bus.ap_done, bus.ap_start_int, bus.ap_loop_init, bus.ap_continue_int};
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, actual ctrl=%b dout=%h", tag, act, bus.dout);
      return;
    end
    e = sb_q.pop_front();
    if (act !== e.ctrl) begin
      n_err++;
      $display("FAIL %s ctrl: actual=%b required=%b (ready,done,start_int,loop_init,continue)",
               tag, act, e.ctrl);
    end
    n_cmp++;
    if (bus.dout !== e.dout) begin
      n_err++;
      $display("FAIL %s dout: actual=%h required=%h", tag, bus.dout, e.dout);
    end
  endtask

  initial begin
    bus.ap_start           = 1'b0;
    bus.ap_ready_int       = 1'b0;
    bus.ap_loop_exit_ready = 1'b0;
    bus.ap_loop_exit_done  = 1'b0;
    bus.din0 = D0;
    bus.din1 = D1;
    bus.din2 = D2;
    bus.sel  = 2'd0;

    //           rst st ri er ed sel ctrl      dout
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 5'b00001, D0); // reset, idle
    tbl[1]  = mk(1, 1, 0, 0, 0, 1, 5'b00111, D1); // reset, start raised
    tbl[2]  = mk(0, 1, 1, 0, 0, 0, 5'b00111, D0); // iteration 0
    tbl[3]  = mk(0, 1, 1, 0, 0, 2, 5'b00101, D2); // iteration 1
    tbl[4]  = mk(0, 1, 1, 0, 0, 3, 5'b00101, D2); // iteration 2
    tbl[5]  = mk(0, 1, 0, 1, 1, 1, 5'b11101, D1); // exit cycle
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, 5'b00111, D0); // init re-armed
    tbl[7]  = mk(0, 1, 1, 0, 0, 2, 5'b00111, D2);
    tbl[8]  = mk(0, 1, 1, 1, 1, 0, 5'b11101, D0); // exit and ready_int together
    tbl[9]  = mk(0, 0, 0, 0, 0, 1, 5'b01001, D1); // done held x5
    tbl[10] = mk(0, 0, 0, 0, 0, 2, 5'b01001, D2);
    tbl[11] = mk(0, 0, 0, 0, 0, 3, 5'b01001, D2);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 5'b01001, D0);
    tbl[13] = mk(0, 0, 0, 0, 0, 1, 5'b01001, D1);
    tbl[14] = mk(0, 1, 0, 0, 0, 2, 5'b00111, D2); // new start clears done, init kept 1
    tbl[15] = mk(0, 1, 1, 0, 0, 3, 5'b00111, D2);
    tbl[16] = mk(0, 1, 0, 0, 1, 0, 5'b01101, D0); // exit_done with start
    tbl[17] = mk(0, 0, 0, 0, 0, 1, 5'b01001, D1); // done_cache set despite start

    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      #1;
      rst                    = tbl[i].rst;
      bus.ap_start           = tbl[i].start;
      bus.ap_ready_int       = tbl[i].rdy_int;
      bus.ap_loop_exit_ready = tbl[i].ex_rdy;
      bus.ap_loop_exit_done  = tbl[i].ex_done;
      bus.sel                = tbl[i].sel;
      push_exp(tbl[i].ctrl, tbl[i].dout);
      @(negedge clk);
      check_out($sformatf("row%0d", i));
    end

    // Async reset between edges with init_reg=0, done_cache=1.
    #2;
    rst = 1'b1;
    push_exp(5'b00001, D1);
    #1;
    check_out("async_rst_idle");
    bus.ap_start = 1'b1;
    push_exp(5'b00111, D1);
    #1;
    check_out("async_rst_start");

    // Release reset, then all four selects inside one cycle.
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.ap_start = 1'b0;
    for (int s = 0; s < 4; s++) begin
      bus.sel = 2'(s);
      push_exp(5'b00001, (s == 0) ? D0 : (s == 1) ? D1 : D2);
      #1;
      check_out($sformatf("mux_same_cycle_sel%0d", s));
    end

    // Random operands.
    for (int k = 0; k < 8; k++) begin
      logic [31:0] a, b, c;
      logic [1:0]  s;
      @(posedge clk);
      #1;
      a = $urandom; b = $urandom; c = $urandom;
      s = 2'($urandom_range(0, 3));
      bus.din0 = a; bus.din1 = b; bus.din2 = c; bus.sel = s;
      push_exp(5'b00001, (s == 2'd0) ? a : (s == 2'd1) ? b : c);
      @(negedge clk);
      check_out($sformatf("mux_rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/loop_seq_ctrl_mux3.md
Name: loop_seq_ctrl_mux3

Overview:
- Reusable control/datapath slice for HLS-style sequential pipelined loops.
- Combines:
  - a loop flow-control sequencer, which bridges the parent ap_start/ap_ready/ap_done handshake to the loop body's internal start/ready/exit signals and generates the first-iteration init pulse;
  - a 3:1 combinational data selector used to pick a loop operand by iteration index.
- Sits between the parent FSM and the loop body, e.g. a 3-element saturating vector-add row loop.

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 1, mux pipeline depth; only 1 (combinational) is supported.
- DIN_WIDTH, 32, width of din0..din2 and dout.
- SEL_WIDTH, 2, width of sel.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- ap_start  in  1  parent start request.
- ap_ready  out  1  to parent: loop accepted its final iteration.
- ap_done  out  1  to parent: loop finished.
- ap_start_int  out  1  start to loop body.
- ap_loop_init  out  1  first-iteration indicator to loop body.
- ap_ready_int  in  1  loop body consumed one iteration.
- ap_loop_exit_ready  in  1  loop body: exit condition reached this cycle.
- ap_loop_exit_done  in  1  loop body: done condition this cycle.
- ap_continue_int  out  1  continue to loop body.
- din0, din1, din2  in  DIN_WIDTH  mux data inputs.
- sel  in  SEL_WIDTH  mux select.
- dout  out  DIN_WIDTH  selected data.

Behaviour:
- Clock and reset: one clock ap_clk; reset ap_rst is asynchronous and active-high.
- Pass-through signals:
  - ap_start_int = ap_start.
  - ap_continue_int = 1, constant.
  - ap_ready = ap_loop_exit_ready.
- init_reg (1 bit):
  - Reset value 1.
  - On a clock edge: if ap_loop_exit_ready=1 then 1; else if ap_ready_int=1 then 0; else hold. Exit has priority.
  - ap_loop_init = init_reg & ap_start.
- done_cache (1 bit):
  - Reset value 0.
  - On a clock edge: if ap_loop_exit_done=1 then 1; else if ap_start=1 then 0; else hold.
- ap_done = ap_loop_exit_done | (done_cache & ~ap_start).
  - A completed loop keeps reporting done while start stays low.
  - Done clears once a new start arrives.
- Outputs while reset is asserted: ap_loop_init = ap_start; ap_done = 0 unless ap_loop_exit_done=1; other outputs follow their pass-through equations.
- Reset mid-loop: init_reg and done_cache return to reset values immediately, without waiting for a clock edge.
- Simultaneous events:
  - exit_ready and ready_int together: init_reg=1.
  - exit_done and start together: done_cache=1.
- Mux (purely combinational, zero latency):
  - sel=0 → dout=din0.
  - sel=1 → dout=din1.
  - sel=2 → dout=din2.
  - sel=3 → dout=din2 (fixed decision).
- Latency:
  - Control outputs are combinational from inputs plus one register each.
  - init_reg and done_cache update one cycle after the triggering event.

Decomposition:
- Shared package holds:
  - localparam SEL_LAST = 2'd2;
  - default widths DIN_WIDTH=32 and SEL_WIDTH=2.
- One natural sub-module: loop_mux3_sel (the 3:1 selector).
- The sequencer stays inline in loop_seq_ctrl_mux3.

Test Plan:
- Reset then idle: assert ap_rst with ap_start=0 → ap_loop_init=0, ap_done=0, ap_ready=0, ap_continue_int=1. Raise ap_start=1 → ap_loop_init=1, ap_start_int=1.
- 3-iteration loop: ap_start=1; pulse ap_ready_int for iterations 0, 1, 2, with ap_loop_exit_ready=ap_loop_exit_done=1 on the 4th cycle.
  - ap_loop_init=1 only in cycle 0, then 0.
  - ap_ready=ap_done=1 in the exit cycle.
  - ap_loop_init=1 again the following cycle.
- Done hold: after exit, drop ap_start → ap_done stays 1 for 5 cycles. Raise ap_start → ap_done=0 on the next cycle.
- Priority: ap_loop_exit_ready=1 and ap_ready_int=1 in the same cycle → init_reg=1 next cycle.
- Async reset mid-loop: with init_reg=0 and done_cache=1, assert ap_rst between edges → ap_loop_init=ap_start and ap_done=0 immediately.
- Mux: din0=0x00000005, din1=0x7FFFFFFF, din2=0x80000000; sel=0,1,2,3 → dout=0x00000005, 0x7FFFFFFF, 0x80000000, 0x80000000, all in the same cycle.
